// File: rtl/seq_div_unit_if.sv
// Operand/result handshake bundle for seq_div_unit.
// slave = divider side, master = operand source / result consumer.
interface seq_div_unit_if #(
  parameter int unsigned DW = 6,
  parameter int unsigned SW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Optional SEQ_DIV_BACK2BACK_EN: accept a new operand pair on the DONE handshake edge.
module seq_div_unit #(
  parameter int unsigned DW = 6,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  seq_div_unit_if.slave bus
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [SW-1:0] dvs_q, dvs_d;
  logic [SW:0]   pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] q_out_q, q_out_d;
  logic [SW-1:0] r_out_q, r_out_d;
  logic          dbz_q, dbz_d;

  logic          accept;
  logic          in_ready;
  logic [SW:0]   pr_shift;
  logic [SW:0]   pr_sub;
  logic [SW:0]   pr_next;
  logic          q_bit;

  always_comb begin
    in_ready = (state_q == IDLE);
`ifdef SEQ_DIV_BACK2BACK_EN
    if (state_q == DONE) in_ready = bus.out_ready;
`endif
  end

  assign accept = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
    end
  end

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    pr_d     = pr_q;
    cnt_d    = cnt_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dbz_d    = dbz_q;

    pr_shift = {pr_q[SW-1:0], dvd_q[DW-1]};
    pr_sub   = pr_shift - {1'b0, dvs_q};
    q_bit    = (pr_shift >= {1'b0, dvs_q});
    pr_next  = q_bit ? pr_sub : pr_shift;

    unique case (state_q)
      IDLE: begin
      end
      CALC: begin
        dvd_d = {dvd_q[DW-2:0], q_bit};
        pr_d  = pr_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = DONE;
          q_out_d = {dvd_q[DW-2:0], q_bit};
          r_out_d = pr_next[SW-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new operand pair overrides the DONE->IDLE return when back-to-back is on.
    if (accept) begin
      dvd_d = bus.dividend;
      dvs_d = bus.divisor;
      if (bus.divisor == '0) begin
        state_d = DONE;
        q_out_d = '1;
        r_out_d = '0;
        dbz_d   = 1'b1;
      end else begin
        state_d = CALC;
        pr_d    = '0;
        cnt_d   = '0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_out_q;
  assign bus.remainder   = r_out_q;
  assign bus.div_by_zero = dbz_q;

  a_rem_lt_div: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DONE && !dbz_q) |-> (r_out_q < dvs_q));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (state_q == DONE && !bus.out_ready) |=>
      ($stable(q_out_q) && $stable(r_out_q) && $stable(dbz_q)));

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: vector table, hand-written corner
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_div_unit;
  localparam int unsigned DW = 6;
  localparam int unsigned SW = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_div_unit_if #(.DW(DW), .SW(SW)) bus ();

  seq_div_unit #(.DW(DW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dvs;
    int exp_q;
    int exp_r;
    int exp_dbz;
    int exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones quotient.
  task automatic model(input int dvd, input int dvs,
                       output int q, output int r, output int dbz, output int lat);
    if (dvs == 0) begin
      q = (1 << DW) - 1; r = 0; dbz = 1; lat = 1;
    end else begin
      q = dvd / dvs; r = dvd % dvs; dbz = 0; lat = DW + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, " in_ready before issue"}, int'(bus.in_ready), 1);
  endtask

  // Issue one op, measure latency, check results, stall 'hold' cycles, handshake.
  task automatic run_op(input int dvd, input int dvs, input int hold,
                        input bit early, input string tag);
    int eq, er, ebz, elat, lat;
    bit busy_ok;
    int exp_rdy;
    model(dvd, dvs, eq, er, ebz, elat);
    tick();
    wait_ready(tag);
    bus.in_valid  = 1'b1;
    bus.dividend  = DW'(dvd);
    bus.divisor   = SW'(dvs);
    bus.out_ready = early;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " in_ready low while busy"}, int'(busy_ok), 1);
    check({tag, " quotient"}, int'(bus.quotient), eq);
    check({tag, " remainder"}, int'(bus.remainder), er);
    check({tag, " div_by_zero"}, int'(bus.div_by_zero), ebz);
`ifdef SEQ_DIV_BACK2BACK_EN
    exp_rdy = int'(bus.out_ready);
`else
    exp_rdy = 0;
`endif
    check({tag, " in_ready in DONE"}, int'(bus.in_ready), exp_rdy);
    if (hold > 0) bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, int'(bus.out_valid), 1);
      check({tag, " hold quotient"}, int'(bus.quotient), eq);
      check({tag, " hold remainder"}, int'(bus.remainder), er);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    vec_t vecs[6];
    int n, n_acc, rdy, eq, er, ebz, elat;
    bit stray_ok;

    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{45, 7,  6, 3, 0, 7};
    vecs[1] = '{63, 1, 63, 0, 0, 7};
    vecs[2] = '{ 5, 7,  0, 5, 0, 7};
    vecs[3] = '{ 0, 3,  0, 0, 0, 7};
    vecs[4] = '{20, 0, 63, 0, 1, 1};
    vecs[5] = '{12, 4,  3, 0, 0, 7};

    #1;
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset quotient", int'(bus.quotient), 0);
    check("reset remainder", int'(bus.remainder), 0);
    check("reset div_by_zero", int'(bus.div_by_zero), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready after reset", int'(bus.in_ready), 1);

    // Table: latency counts the accept edge as edge 1.
    foreach (vecs[i]) begin
      tick();
      wait_ready("vec");
      bus.in_valid  = 1'b1;
      bus.dividend  = DW'(vecs[i].dvd);
      bus.divisor   = SW'(vecs[i].dvs);
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 40) begin
        check($sformatf("vec%0d in_ready busy", i), int'(bus.in_ready), 0);
        tick();
        n++;
      end
      check($sformatf("vec%0d latency", i), n, vecs[i].exp_lat);
      check($sformatf("vec%0d quotient", i), int'(bus.quotient), vecs[i].exp_q);
      check($sformatf("vec%0d remainder", i), int'(bus.remainder), vecs[i].exp_r);
      check($sformatf("vec%0d div_by_zero", i), int'(bus.div_by_zero), vecs[i].exp_dbz);
      tick();
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d out_valid dropped", i), int'(bus.out_valid), 0);
    end

    // 50/6 stalled 4 cycles with a stray in_valid that must be ignored.
    tick();
    wait_ready("stall");
    bus.in_valid = 1'b1;
    bus.dividend = DW'(50);
    bus.divisor  = SW'(6);
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("stall latency", n, 7);
    bus.in_valid = 1'b1;
    bus.dividend = DW'(9);
    bus.divisor  = SW'(2);
    stray_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.in_ready) stray_ok = 1'b0;
      tick();
      check("stall valid", int'(bus.out_valid), 1);
      check("stall quotient", int'(bus.quotient), 8);
      check("stall remainder", int'(bus.remainder), 2);
    end
    check("stall in_ready low", int'(stray_ok), 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall handshake", int'(bus.out_valid), 0);

    // Reset 3 cycles into CALC of 33/5.
    tick();
    wait_ready("rst");
    bus.in_valid = 1'b1;
    bus.dividend = DW'(33);
    bus.divisor  = SW'(5);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check("midcalc reset out_valid", int'(bus.out_valid), 0);
    check("midcalc reset quotient", int'(bus.quotient), 0);
    check("midcalc reset remainder", int'(bus.remainder), 0);
    check("midcalc reset div_by_zero", int'(bus.div_by_zero), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post reset in_ready", int'(bus.in_ready), 1);
    check("post reset out_valid", int'(bus.out_valid), 0);
    run_op(33, 5, 0, 1'b0, "reissue 33/5");

    // Randomized ops; early out_ready during CALC must have no effect.
    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand");
    end

    // Back-to-back: 30/4 presented together with the 45/7 result handshake.
    tick();
    wait_ready("b2b");
    bus.in_valid = 1'b1;
    bus.dividend = DW'(45);
    bus.divisor  = SW'(7);
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    model(45, 7, eq, er, ebz, elat);
    check("b2b first quotient", int'(bus.quotient), eq);
    check("b2b first remainder", int'(bus.remainder), er);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = DW'(30);
    bus.divisor   = SW'(4);
    n = 0;
    n_acc = 0;
    while (n < 30 && (bus.in_valid || !bus.out_valid)) begin
      rdy = int'(bus.in_ready);
      tick();
      n++;
      if (n == 1) bus.out_ready = 1'b0;
      if (rdy != 0 && bus.in_valid) begin
        bus.in_valid = 1'b0;
        n_acc = n;
      end
    end
`ifdef SEQ_DIV_BACK2BACK_EN
    check("b2b accept edge", n_acc, 1);
    check("b2b second latency", n, 7);
`else
    check("b2b accept edge", n_acc, 2);
    check("b2b second latency", n, 8);
`endif
    model(30, 4, eq, er, ebz, elat);
    check("b2b second quotient", int'(bus.quotient), eq);
    check("b2b second remainder", int'(bus.remainder), er);
    check("b2b second div_by_zero", int'(bus.div_by_zero), ebz);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("b2b final handshake", int'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Multi-cycle restoring divider; the inverse of the registered multiply/add pipeline.
- Takes a DW-bit dividend (e.g. a pipeline result) and an SW-bit divisor. Returns quotient and remainder through valid/ready handshakes on both sides.
- Sits downstream of the arithmetic pipeline to recover operands and check results.

Parameters:
- DW, 6, dividend and quotient width.
- SW, 3, divisor and remainder width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- dividend  input  DW  unsigned dividend.
- divisor  input  SW  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  DW  unsigned quotient.
- remainder  output  SW  unsigned remainder.
- div_by_zero  output  1  flags a result produced from divisor==0.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Inputs are ignored while rst=0.
- in_ready is decoded from state: 1 in IDLE only (DONE exception under the optional feature). out_valid=1 in DONE only.
- States: IDLE, CALC, DONE.
- IDLE:
  - On in_valid&&in_ready: latch dividend and divisor.
  - If divisor!=0: clear partial remainder and counter, go to CALC.
  - If divisor==0: go to DONE with quotient=all ones, remainder=0, div_by_zero=1. Latency is 1 cycle.
- CALC, one quotient bit per cycle, MSB first:
  - Partial remainder is SW+1 bits wide: pr = {pr[SW-1:0], next dividend bit}.
  - If pr >= divisor: pr = pr - divisor and the quotient bit is 1; else the quotient bit is 0.
  - Counter increments each cycle. After DW iterations, go to DONE with remainder=pr[SW-1:0] and div_by_zero=0.
  - Latency from the accept edge to out_valid high is DW+1 edges (7 for defaults).
- DONE:
  - quotient, remainder and div_by_zero are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. out_valid drops on the following edge.
- Outputs change only on DONE entry; they are not cleared on leaving DONE.
- Arithmetic: all unsigned. Invariant for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Boundaries:
  - Dividend 0 gives q=0, r=0.
  - Divisor 1 gives q=dividend.
  - Dividend < divisor gives q=0, r=dividend.
  - in_valid asserted outside IDLE is ignored; the source must hold it until in_ready.
  - Reset mid-CALC or in DONE aborts immediately; no output handshake occurs and in_ready=1 after reset release.
  - out_ready asserted outside DONE has no effect.

Optional Feature:
- Macro: SEQ_DIV_BACK2BACK_EN.
- Defined: in DONE, in_ready = out_ready. A simultaneous output handshake and input accept goes directly to CALC, or to DONE for divisor 0, skipping IDLE. Throughput is one result per DW+1 cycles.
- Undefined: DONE always returns to IDLE first; one idle bubble between operations.

Test Plan:
- Reset then 45/7 with out_ready=1 -> out_valid high exactly 7 edges after accept; q=6, r=3, div_by_zero=0.
- 63/1, then 5/7, then 0/3 -> (q=63,r=0), (q=0,r=5), (q=0,r=0); in_ready=0 throughout CALC and DONE.
- 20/0 -> out_valid 1 edge after accept; q=63, r=0, div_by_zero=1. The next op 12/4 -> q=3, r=0, div_by_zero=0.
- 50/6 with out_ready held low 4 cycles after out_valid -> q=8, r=2 stable all 4 cycles; a new in_valid is ignored; handshake completes when out_ready rises.
- Assert rst low 3 cycles into CALC of 33/5 -> out_valid=0 and all outputs 0 asynchronously; after release in_ready=1, and 33/5 re-issued -> q=6, r=3.
- With SEQ_DIV_BACK2BACK_EN: 45/7 then 30/4 presented while out_ready=1 -> second accept on the first result's handshake edge; second result q=7, r=2, 7 edges later with no bubble. Without the macro: one extra cycle.
